mem_dp_clr: RTL

Parametrised successor to the single-port mem block. It is a synchronous dual-port RAM with one write port and one read port. Additional features:
- per-bit write mask
- registered read with a valid flag
- selectable read-during-write bypass
- hardware clear engine that sweeps the whole array to a constant after reset or on request

It serves as a general scratch and state store for the sequential blocks in this library.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_dp_array.sv | 54 +++++
 rtl/mem_dp_clr.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port RAM with clear engine.
package mem_pkg;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_e;

  function automatic int unsigned depth_of(int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/mem_dp_array.sv
// Storage array: one bit-masked write port, one registered read port with optional
// same-address bypass. Only the read data register is reset; the storage is not.
module mem_dp_array
  import mem_pkg::*;
#(
  parameter int unsigned AW     = 2,
  parameter int unsigned DW     = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] wmask_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [depth_of(AW)];
  logic [DW-1:0] merged;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rdata_q;

  always_comb begin
    merged = (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
  end

  // Bypass forwards the merged word, not raw wdata, so masked-off bits keep old content.
  always_comb begin
    rd_word = mem_q[raddr_i];
    if ((BYPASS != 0) && we_i && (waddr_i == raddr_i)) begin
      rd_word = merged;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= merged;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_word;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_dp_clr.sv
// Dual-port RAM with a clear engine that sweeps every word to CLR_VAL after reset or
// on request; user traffic is locked out while the sweep owns the array.
module mem_dp_clr
  import mem_pkg::*;
#(
  parameter int unsigned   AW      = 2,
  parameter int unsigned   DW      = 3,
  parameter logic [DW-1:0] CLR_VAL = '0,
  parameter int unsigned   BYPASS  = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_req_i,
  output logic          busy_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] wmask_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o
);

  localparam int unsigned   Depth    = depth_of(AW);
  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

  state_e        state_q;
  logic [AW-1:0] clr_ptr_q;
  logic          rvalid_q;
  logic          clearing;

  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_wmask;
  logic          arr_re;

  assign clearing = (state_q == StClear);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= !clearing && re_i;
      unique case (state_q)
        StClear: begin
          // Pointer wraps to zero on the last write, ready for the next sweep.
          clr_ptr_q <= clr_ptr_q + AW'(1);
          if (clr_ptr_q == LastAddr) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (clr_req_i) begin
            state_q <= StClear;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  always_comb begin
    arr_we    = we_i;
    arr_waddr = waddr_i;
    arr_wdata = wdata_i;
    arr_wmask = wmask_i;
    arr_re    = re_i;
    if (clearing) begin
      arr_we    = 1'b1;
      arr_waddr = clr_ptr_q;
      arr_wdata = CLR_VAL;
      arr_wmask = '1;
      arr_re    = 1'b0;
    end
  end

  mem_dp_array #(
    .AW    (AW),
    .DW    (DW),
    .BYPASS(BYPASS)
  ) u_array (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (arr_we),
    .waddr_i(arr_waddr),
    .wdata_i(arr_wdata),
    .wmask_i(arr_wmask),
    .re_i   (arr_re),
    .raddr_i(raddr_i),
    .rdata_o(rdata_o)
  );

  assign busy_o   = clearing;
  assign rvalid_o = rvalid_q;

endmodule
